// File: rtl/e_alloc_pkg.sv
// Shared width helpers and population count for the circular slot allocator.
package e_alloc_pkg;

    localparam int POP_W = 256;  // widest slot vector popcount() accepts

    function automatic int alloc_id_w(input int w);
        return $clog2(w);
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int popcount(input logic [POP_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/e_alloc_find.sv
// Combinational circular zero finder: first 0 bit of vec_i searching pos-1, pos-2, ... wrapping, pos last.
// Two-level search: per-group any over RADIX_N bits, then first bit inside the winning group.
module e_alloc_find
    import e_alloc_pkg::*;
#(
    parameter int W       = 32,
    parameter int RADIX_N = 4,
    localparam int IW     = alloc_id_w(W)
) (
    input  logic [W-1:0]  vec_i,
    input  logic [IW-1:0] pos_i,
    output logic [W-1:0]  onehot_o,
    output logic [IW-1:0] id_o,
    output logic          any_o
);

    localparam int NG = (W + RADIX_N - 1) / RADIX_N;

    logic [NG*RADIX_N-1:0] rot;
    logic [NG-1:0]         grp_any;

    // rot[i] is the free flag of the i-th slot in search order; pad bits stay 0
    always_comb begin
        logic [IW-1:0] src;
        src = '0;
        rot = '0;
        for (int i = 0; i < W; i++) begin
            src    = pos_i - IW'(1) - IW'(i);
            rot[i] = ~vec_i[src];
        end
    end

    always_comb begin
        grp_any = '0;
        for (int g = 0; g < NG; g++) begin
            grp_any[g] = |rot[g*RADIX_N +: RADIX_N];
        end
    end

    always_comb begin
        logic               found_g;
        logic               found_b;
        int                 sel_g;
        int                 sel_b;
        logic [RADIX_N-1:0] grp;
        found_g = 1'b0;
        found_b = 1'b0;
        sel_g   = 0;
        sel_b   = 0;
        for (int g = 0; g < NG; g++) begin
            if (!found_g && grp_any[g]) begin
                found_g = 1'b1;
                sel_g   = g;
            end
        end
        grp = rot[sel_g*RADIX_N +: RADIX_N];
        for (int b = 0; b < RADIX_N; b++) begin
            if (!found_b && grp[b]) begin
                found_b = 1'b1;
                sel_b   = b;
            end
        end
        any_o    = |grp_any;
        id_o     = pos_i - IW'(1) - IW'(sel_g * RADIX_N + sel_b);
        onehot_o = any_o ? (W'(1) << id_o) : '0;
    end

endmodule

// File: rtl/e_alloc.sv
// Circular slot allocator: up to ALLOC_N same-cycle grants from a rotating pointer, multi-slot free mask.
// Grants are combinational off registered occupancy; freed slots become grantable the following cycle.
module e_alloc
    import e_alloc_pkg::*;
#(
    parameter int W       = 32,
    parameter int ALLOC_N = 2,
    parameter int RADIX_N = 4,
    localparam int IW     = alloc_id_w(W),
    localparam int CW     = cnt_w(W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ALLOC_N-1:0]          alloc_req_i,
    output logic [ALLOC_N-1:0]          alloc_gnt_o,
    output logic [ALLOC_N-1:0][IW-1:0]  alloc_id_o,
    input  logic [W-1:0]                free_i,
    output logic [W-1:0]                busy_o,
    output logic [CW-1:0]               count_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        err_o
);

    logic [W-1:0]  busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          err_q, err_d;
    logic [W-1:0]  free_eff;
    logic [W-1:0]  grant_mask;

    // Each channel searches occupancy plus whatever earlier requesting channels just took
    for (genvar k = 0; k < ALLOC_N; k++) begin : g_ch
        logic [W-1:0]  vec;
        logic [W-1:0]  oh;
        logic [W-1:0]  vec_nxt;
        logic [IW-1:0] id;
        logic          any;

        if (k == 0) begin : g_head
            assign vec = busy_q;
        end else begin : g_tail
            assign vec = g_ch[k-1].vec_nxt;
        end

        e_alloc_find #(
            .W       (W),
            .RADIX_N (RADIX_N)
        ) u_find (
            .vec_i    (vec),
            .pos_i    (ptr_q),
            .onehot_o (oh),
            .id_o     (id),
            .any_o    (any)
        );

        assign vec_nxt        = vec | (alloc_req_i[k] ? oh : '0);
        assign alloc_gnt_o[k] = alloc_req_i[k] & any & ~rst;
        assign alloc_id_o[k]  = id;
    end

    assign grant_mask = g_ch[ALLOC_N-1].vec_nxt & ~busy_q;
    assign free_eff   = free_i & busy_q;

    always_comb begin
        busy_d  = (busy_q & ~free_eff) | grant_mask;
        ptr_d   = ptr_q;
        for (int k = 0; k < ALLOC_N; k++) begin
            if (alloc_gnt_o[k]) begin
                ptr_d = alloc_id_o[k];
            end
        end
        count_d = CW'(int'(count_q) - popcount(POP_W'(free_eff)) + popcount(POP_W'(grant_mask)));
        full_d  = (count_d == CW'(W));
        empty_d = (count_d == '0);
        err_d   = |(free_i & ~busy_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_e_alloc.sv
// Directed bench for e_alloc at W=8, ALLOC_N=2 with hand-computed expected grants and state.
module tb_e_alloc;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      gnt;
    logic [1:0][2:0] id;
    logic [7:0]      free;
    logic [7:0]      busy;
    logic [3:0]      count;
    logic            full;
    logic            empty;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;

    e_alloc #(
        .W       (8),
        .ALLOC_N (2),
        .RADIX_N (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req_i (req),
        .alloc_gnt_o (gnt),
        .alloc_id_o  (id),
        .free_i      (free),
        .busy_o      (busy),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] b, input logic [3:0] c,
                             input logic f, input logic e, input logic r);
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".full"},  32'(full),  32'(f));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".err"},   32'(err),   32'(r));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 2'b11;
        free = 8'hFF;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        tick();
        chk_state("reset", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("rst_gnt2", 32'(gnt), 32'h0);

        // first allocation from ptr=0: search 7, 6, ...
        rst  = 1'b0;
        free = 8'h00;
        req  = 2'b11;
        #1;
        chk("a1_gnt", 32'(gnt), 32'h3);
        chk("a1_id0", 32'(id[0]), 32'd7);
        chk("a1_id1", 32'(id[1]), 32'd6);
        tick();
        chk_state("a1", 8'hC0, 4'd2, 1'b0, 1'b0, 1'b0);

        // idle channel 0 consumes nothing
        req = 2'b10;
        #1;
        chk("a2_gnt", 32'(gnt), 32'h2);
        chk("a2_id1", 32'(id[1]), 32'd5);
        tick();
        chk_state("a2", 8'hE0, 4'd3, 1'b0, 1'b0, 1'b0);

        req = 2'b11;
        #1;
        chk("a3_id0", 32'(id[0]), 32'd4);
        chk("a3_id1", 32'(id[1]), 32'd3);
        tick();
        chk_state("a3", 8'hF8, 4'd5, 1'b0, 1'b0, 1'b0);
        #1;
        chk("a4_gnt", 32'(gnt), 32'h3);
        chk("a4_id0", 32'(id[0]), 32'd2);
        chk("a4_id1", 32'(id[1]), 32'd1);
        tick();
        chk_state("a4", 8'hFE, 4'd7, 1'b0, 1'b0, 1'b0);

        // one free slot, two requests: only channel 0 wins
        #1;
        chk("a5_gnt", 32'(gnt), 32'h1);
        chk("a5_id0", 32'(id[0]), 32'd0);
        tick();
        chk_state("full", 8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("full_gnt", 32'(gnt), 32'h0);

        // free and request in the same cycle: no bypass
        free = 8'h10;
        req  = 2'b01;
        #1;
        chk("fa_gnt", 32'(gnt), 32'h0);
        tick();
        chk_state("fa", 8'hEF, 4'd7, 1'b0, 1'b0, 1'b0);
        free = 8'h00;
        #1;
        chk("fa2_gnt", 32'(gnt), 32'h1);
        chk("fa2_id0", 32'(id[0]), 32'd4);
        tick();
        chk_state("fa2", 8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);

        // build busy=F6 with ptr=1 for the wrap-around case
        req  = 2'b00;
        free = 8'h0B;
        tick();
        chk_state("w0", 8'hF4, 4'd5, 1'b0, 1'b0, 1'b0);
        free = 8'h00;
        req  = 2'b11;
        #1;
        chk("w1_id0", 32'(id[0]), 32'd3);
        chk("w1_id1", 32'(id[1]), 32'd1);
        tick();
        req  = 2'b00;
        free = 8'h08;
        tick();
        chk_state("w2", 8'hF6, 4'd6, 1'b0, 1'b0, 1'b0);
        free = 8'h00;
        req  = 2'b11;
        #1;
        chk("wrap_gnt", 32'(gnt), 32'h3);
        chk("wrap_id0", 32'(id[0]), 32'd0);
        chk("wrap_id1", 32'(id[1]), 32'd3);
        tick();
        chk_state("wrap", 8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);

        // ptr should now be 3: freed slots 2 and 6 come out as 2 then 6
        free = 8'h44;
        #1;
        chk("p3_gnt_full", 32'(gnt), 32'h0);
        tick();
        chk_state("p3a", 8'hBB, 4'd6, 1'b0, 1'b0, 1'b0);
        free = 8'h00;
        #1;
        chk("p3_id0", 32'(id[0]), 32'd2);
        chk("p3_id1", 32'(id[1]), 32'd6);
        tick();
        chk_state("p3b", 8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);

        // bad free: slot 1 already idle
        req  = 2'b00;
        free = 8'hFE;
        tick();
        chk_state("bf0", 8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
        free = 8'h03;
        tick();
        chk_state("bf1", 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        free = 8'h00;
        tick();
        chk_state("bf2", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);

        // reset in the middle of allocation (ptr=6 here)
        req = 2'b11;
        #1;
        chk("m_id0", 32'(id[0]), 32'd5);
        chk("m_id1", 32'(id[1]), 32'd4);
        tick();
        chk_state("m0", 8'h30, 4'd2, 1'b0, 1'b0, 1'b0);
        rst  = 1'b1;
        free = 8'hFF;
        #1;
        chk("m_rst_gnt", 32'(gnt), 32'h0);
        tick();
        rst  = 1'b0;
        free = 8'h00;
        chk_state("m_rst", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("post_rst_id0", 32'(id[0]), 32'd7);
        chk("post_rst_id1", 32'(id[1]), 32'd6);
        chk("post_rst_gnt", 32'(gnt), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
